// File: rtl/trig_vector_unit.sv
// trig_vector_unit: turns a heading index and speed into signed (dx, dy)
// components using an external quarter-wave sine table. Each request walks
// IDLE -> SIN -> COS -> CALC -> DONE and holds its result until consumed.
module trig_vector_unit #(
    parameter int STEPS   = 44,
    parameter int ANGLE_W = 6,
    parameter int DATA_W  = 8,
    parameter int SPEED_W = 4
) (
    input  logic                              Clk,
    input  logic                              Reset_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ANGLE_W-1:0]                angle,
    input  logic [SPEED_W-1:0]                speed,
    input  logic                              reverse,
    output logic [ANGLE_W-1:0]                rom_addr,
    input  logic [DATA_W-1:0]                 rom_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [DATA_W+SPEED_W:0]    dx,
    output logic signed [DATA_W+SPEED_W:0]    dy,
    output logic                              err
);

    localparam int OUT_W   = DATA_W + SPEED_W + 1;
    localparam int QUARTER = STEPS / 4;

    // Wide constants carry the extra bit needed for the reverse half-turn sum.
    localparam logic [ANGLE_W:0]   STEPS_W = (ANGLE_W+1)'(STEPS);
    localparam logic [ANGLE_W:0]   HALF_W  = (ANGLE_W+1)'(STEPS / 2);
    localparam logic [ANGLE_W:0]   Q1_W    = (ANGLE_W+1)'(QUARTER);
    localparam logic [ANGLE_W:0]   Q2_W    = (ANGLE_W+1)'(2 * QUARTER);
    localparam logic [ANGLE_W:0]   Q3_W    = (ANGLE_W+1)'(3 * QUARTER);
    localparam logic [ANGLE_W-1:0] Q1_N    = ANGLE_W'(QUARTER);
    localparam logic [ANGLE_W-1:0] Q2_N    = ANGLE_W'(2 * QUARTER);
    localparam logic [ANGLE_W-1:0] Q3_N    = ANGLE_W'(3 * QUARTER);

    typedef enum logic [2:0] {
        IDLE,
        SIN,
        COS,
        CALC,
        DONE
    } state_t;

    state_t             state;
    logic [ANGLE_W:0]   a_lat;
    logic [SPEED_W-1:0] speed_lat;
    logic               err_lat;
    logic [DATA_W-1:0]  sin_mag;

    logic               angle_bad;
    logic [ANGLE_W:0]   eff_angle;
    logic [1:0]         quad;
    logic [ANGLE_W-1:0] offset;
    logic [ANGLE_W-1:0] sin_idx;
    logic [ANGLE_W-1:0] cos_idx;
    logic               sin_neg;
    logic               cos_neg;
    logic [OUT_W-1:0]   sin_prod;
    logic [OUT_W-1:0]   cos_prod;

    // Effective angle for the incoming request, folding the half turn back into range.
    always_comb begin
        angle_bad = ({1'b0, angle} >= STEPS_W);
        eff_angle = {1'b0, angle} + (reverse ? HALF_W : '0);
        if (eff_angle >= STEPS_W) begin
            eff_angle = eff_angle - STEPS_W;
        end
    end

    // Quadrant, in-quadrant offset, mirrored table indices and sign flips for the latched angle.
    always_comb begin
        quad   = 2'd0;
        offset = a_lat[ANGLE_W-1:0];
        if (a_lat >= Q3_W) begin
            quad   = 2'd3;
            offset = a_lat[ANGLE_W-1:0] - Q3_N;
        end else if (a_lat >= Q2_W) begin
            quad   = 2'd2;
            offset = a_lat[ANGLE_W-1:0] - Q2_N;
        end else if (a_lat >= Q1_W) begin
            quad   = 2'd1;
            offset = a_lat[ANGLE_W-1:0] - Q1_N;
        end
        sin_idx  = quad[0] ? (Q1_N - offset) : offset;
        cos_idx  = quad[0] ? offset : (Q1_N - offset);
        sin_neg  = quad[1];
        cos_neg  = quad[1] ^ quad[0];
        sin_prod = OUT_W'(sin_mag) * OUT_W'(speed_lat);
        cos_prod = OUT_W'(rom_data) * OUT_W'(speed_lat);
    end

    // Table address is only live during the two read states, and parked for bad angles.
    always_comb begin
        req_ready = (state == IDLE);
        rom_addr  = '0;
        if (!err_lat) begin
            if (state == SIN) begin
                rom_addr = sin_idx;
            end else if (state == COS) begin
                rom_addr = cos_idx;
            end
        end
    end

    // Request sequencer with registered result outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            a_lat     <= '0;
            speed_lat <= '0;
            err_lat   <= 1'b0;
            sin_mag   <= '0;
            out_valid <= 1'b0;
            dx        <= '0;
            dy        <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_lat     <= eff_angle;
                        speed_lat <= speed;
                        err_lat   <= angle_bad;
                        state     <= SIN;
                    end
                end
                SIN: begin
                    state <= COS;
                end
                COS: begin
                    sin_mag <= rom_data;
                    state   <= CALC;
                end
                CALC: begin
                    if (err_lat) begin
                        dx  <= '0;
                        dy  <= '0;
                        err <= 1'b1;
                    end else begin
                        dx  <= $signed(cos_neg ? (-cos_prod) : cos_prod);
                        dy  <= $signed(sin_neg ? (-sin_prod) : sin_prod);
                        err <= 1'b0;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trig_vector_unit.sv
// tb_trig_vector_unit: directed vectors against a registered quarter-wave
// sine ROM holding round(255*sin(k*90/11 deg)), k = 0..11.
module tb_trig_vector_unit;

    localparam int STEPS   = 44;
    localparam int ANGLE_W = 6;
    localparam int DATA_W  = 8;
    localparam int SPEED_W = 4;
    localparam int OUT_W   = DATA_W + SPEED_W + 1;

    logic                     Clk;
    logic                     Reset_n;
    logic                     req_valid;
    logic                     req_ready;
    logic [ANGLE_W-1:0]       angle;
    logic [SPEED_W-1:0]       speed;
    logic                     reverse;
    logic [ANGLE_W-1:0]       rom_addr;
    logic [DATA_W-1:0]        rom_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  dx;
    logic signed [OUT_W-1:0]  dy;
    logic                     err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int angle;
        int speed;
        int rev;
        int sinIdx;
        int cosIdx;
        int dx;
        int dy;
        int err;
    } vec_t;

    vec_t vecs[14];
    int   romTable[12];

    trig_vector_unit #(
        .STEPS(STEPS), .ANGLE_W(ANGLE_W), .DATA_W(DATA_W), .SPEED_W(SPEED_W)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .angle(angle), .speed(speed), .reverse(reverse),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .dx(dx), .dy(dy), .err(err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous ROM: data appears one cycle after the address.
    always_ff @(posedge Clk) begin
        rom_data <= (int'(rom_addr) <= 11) ? DATA_W'(romTable[rom_addr]) : '0;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // One full transaction: accept, walk the read states, check result, hand it off.
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge Clk);
        checkOutput({tag, "_req_ready"}, int'(req_ready), 1);
        req_valid = 1'b1;
        angle     = ANGLE_W'(v.angle);
        speed     = SPEED_W'(v.speed);
        reverse   = v.rev[0];
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        checkOutput({tag, "_sin_addr"}, int'(rom_addr), v.sinIdx);
        checkOutput({tag, "_valid_c1"}, int'(out_valid), 0);
        @(posedge Clk);
        #1;
        checkOutput({tag, "_cos_addr"}, int'(rom_addr), v.cosIdx);
        checkOutput({tag, "_valid_c2"}, int'(out_valid), 0);
        @(posedge Clk);
        #1;
        checkOutput({tag, "_calc_addr"}, int'(rom_addr), 0);
        checkOutput({tag, "_valid_c3"}, int'(out_valid), 0);
        @(posedge Clk);
        #1;
        checkOutput({tag, "_valid_c4"}, int'(out_valid), 1);
        checkOutput({tag, "_dx"}, int'(dx), v.dx);
        checkOutput({tag, "_dy"}, int'(dy), v.dy);
        checkOutput({tag, "_err"}, int'(err), v.err);
        checkOutput({tag, "_ready_done"}, int'(req_ready), 0);
        @(negedge Clk);
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_valid_after"}, int'(out_valid), 0);
    endtask

    initial begin
        romTable = '{0, 36, 72, 106, 138, 167, 193, 215, 232, 245, 252, 255};

        //           angle spd rev sinI cosI   dx     dy   err
        vecs[0]  = '{0,    1,  0,  0,   11,    255,   0,    0};
        vecs[1]  = '{22,   2,  0,  0,   11,   -510,   0,    0};
        vecs[2]  = '{11,   1,  1,  11,  0,     0,    -255,  0};
        vecs[3]  = '{50,   3,  0,  0,   0,     0,     0,    1};
        vecs[4]  = '{5,    1,  0,  5,   6,     193,   167,  0};
        vecs[5]  = '{14,   3,  0,  8,   3,    -318,   696,  0};
        vecs[6]  = '{27,   15, 0,  5,   6,    -2895, -2505, 0};
        vecs[7]  = '{40,   2,  0,  4,   7,     430,  -276,  0};
        vecs[8]  = '{43,   1,  1,  1,   10,   -252,   36,   0};
        vecs[9]  = '{0,    0,  0,  0,   11,    0,     0,    0};
        vecs[10] = '{44,   5,  1,  0,   0,     0,     0,    1};
        vecs[11] = '{33,   4,  0,  11,  0,     0,    -1020, 0};
        vecs[12] = '{11,   1,  0,  11,  0,     0,     255,  0};
        vecs[13] = '{63,   1,  0,  0,   0,     0,     0,    1};

        Reset_n   = 1'b0;
        req_valid = 1'b0;
        angle     = '0;
        speed     = '0;
        reverse   = 1'b0;
        out_ready = 1'b0;

        // Reset state while held low and just after release.
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_dx", int'(dx), 0);
        checkOutput("rst_dy", int'(dy), 0);
        checkOutput("rst_err", int'(err), 0);
        checkOutput("rst_rom_addr", int'(rom_addr), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        checkOutput("rel_req_ready", int'(req_ready), 1);
        checkOutput("rel_out_valid", int'(out_valid), 0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Stall in DONE with a second request waiting.
        @(negedge Clk);
        req_valid = 1'b1;
        angle     = 6'd5;
        speed     = 4'd1;
        reverse   = 1'b0;
        @(posedge Clk);
        #1;
        angle = 6'd14;
        speed = 4'd3;
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("hold_valid_c4", int'(out_valid), 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge Clk);
            #1;
            checkOutput($sformatf("hold%0d_valid", c), int'(out_valid), 1);
            checkOutput($sformatf("hold%0d_dx", c), int'(dx), 193);
            checkOutput($sformatf("hold%0d_dy", c), int'(dy), 167);
            checkOutput($sformatf("hold%0d_err", c), int'(err), 0);
            checkOutput($sformatf("hold%0d_ready", c), int'(req_ready), 0);
        end
        @(negedge Clk);
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        out_ready = 1'b0;
        checkOutput("hs_idle_ready", int'(req_ready), 1);
        checkOutput("hs_idle_valid", int'(out_valid), 0);
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        checkOutput("second_sin_addr", int'(rom_addr), 8);
        checkOutput("second_ready", int'(req_ready), 0);
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("second_valid", int'(out_valid), 1);
        checkOutput("second_dx", int'(dx), -318);
        checkOutput("second_dy", int'(dy), 696);
        @(negedge Clk);
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        out_ready = 1'b0;

        // Reset pulse while the unit is in COS aborts the transaction.
        @(negedge Clk);
        req_valid = 1'b1;
        angle     = 6'd5;
        speed     = 4'd2;
        reverse   = 1'b0;
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        @(posedge Clk);
        #1;
        checkOutput("mid_cos_addr", int'(rom_addr), 6);
        Reset_n = 1'b0;
        #2;
        checkOutput("mid_rst_valid", int'(out_valid), 0);
        checkOutput("mid_rst_dx", int'(dx), 0);
        checkOutput("mid_rst_dy", int'(dy), 0);
        checkOutput("mid_rst_err", int'(err), 0);
        checkOutput("mid_rst_addr", int'(rom_addr), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        checkOutput("mid_rel_ready", int'(req_ready), 1);
        checkOutput("mid_rel_valid", int'(out_valid), 0);
        repeat (4) @(posedge Clk);
        #1;
        checkOutput("mid_abort_valid", int'(out_valid), 0);
        checkOutput("mid_abort_dx", int'(dx), 0);

        applyStimulus(vecs[5], 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trig_vector_unit.md
TRIG_VECTOR_UNIT -- requirements
Module: trig_vector_unit

Interface
REQ-001 SHALL have parameter STEPS, default 44, meaning angle steps per full revolution; a multiple of 4.
REQ-002 SHALL have parameter ANGLE_W, default 6, meaning angle width, with 2^ANGLE_W > STEPS.
REQ-003 SHALL have parameter DATA_W, default 8, meaning unsigned table magnitude width.
REQ-004 SHALL have parameter SPEED_W, default 4, meaning unsigned speed width.
REQ-005 SHALL have port Clk, input, 1 bit, the single clock; all state on rising edge.
REQ-006 SHALL have port Reset_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1 bit, request present.
REQ-008 SHALL have port req_ready, output, 1 bit, request accepted this cycle when high with req_valid.
REQ-009 SHALL have port angle, input, ANGLE_W bits, requested heading index.
REQ-010 SHALL have port speed, input, SPEED_W bits, magnitude multiplier.
REQ-011 SHALL have port reverse, input, 1 bit, adds a half turn to angle.
REQ-012 SHALL have port rom_addr, output, ANGLE_W bits, quarter-wave table index 0..Q, where Q = STEPS/4.
REQ-013 SHALL have port rom_data, input, DATA_W bits, table value; valid one cycle after rom_addr.
REQ-014 SHALL have port out_valid, output, 1 bit, result present.
REQ-015 SHALL have port out_ready, input, 1 bit, consumer accepts result.
REQ-016 SHALL have port dx, output, signed DATA_W+SPEED_W+1 bits, cos component times speed.
REQ-017 SHALL have port dy, output, signed DATA_W+SPEED_W+1 bits, sin component times speed.
REQ-018 SHALL have port err, output, 1 bit, request had angle >= STEPS.

Function
REQ-019 SHALL implement FSM states IDLE, SIN, COS, CALC, DONE.
REQ-020 SHALL assert req_ready only in IDLE; IDLE->SIN on req_valid, latching angle, speed and reverse.
REQ-021 SHALL form the effective angle a = (angle + (reverse ? STEPS/2 : 0)) mod STEPS at latch.
REQ-022 SHALL compute quadrant q = a / Q and offset r = a - q*Q.
REQ-023 SHALL use sin index r and cos index Q-r for q even, and sin index Q-r and cos index r for q odd.
REQ-024 SHALL negate sin when q is 2 or 3, and negate cos when q is 1 or 2.
REQ-025 SHALL drive the sin index in SIN, capture rom_data and drive the cos index in COS, and capture rom_data in CALC.
REQ-026 SHALL transition SIN->COS->CALC->DONE unconditionally.
REQ-027 SHALL register dx, dy and err on entry to DONE.
REQ-028 SHALL assert out_valid exactly 4 cycles after the accept edge.
REQ-029 SHALL hold out_valid, dx, dy and err stable in DONE until out_ready; DONE->IDLE on out_ready.
REQ-030 SHALL let a new request be accepted no earlier than the cycle after the DONE->IDLE transition.
REQ-031 SHALL compute products as full-width signed; no truncation or saturation.
REQ-032 SHALL, when the latched angle >= STEPS, skip table reads, still traverse all states with identical latency, and output dx = dy = 0 with err = 1.
REQ-033 SHALL produce exactly 0 for a zero table value, never a negative-zero pattern.
REQ-034 SHALL hold rom_addr at 0 outside SIN and COS.

Reset
REQ-035 SHALL, on Reset_n low at any time including mid-operation, go to IDLE and abort any pending result.
REQ-036 SHALL drive out_valid=0, dx=0, dy=0, err=0 and rom_addr=0 while Reset_n is low and after release.
REQ-037 SHALL assert req_ready in the first cycle after Reset_n release.

Verification (STEPS=44, Q=11; bench ROM returns round(255*sin(k*90/11 deg)))
REQ-038 SHALL verify that angle=0, speed=1, reverse=0 gives rom_addr sequence 0 then 11, and dx=+255, dy=0, err=0, with out_valid on cycle 4.
REQ-039 SHALL verify that angle=22, speed=2 gives dx=-510 and dy=0.
REQ-040 SHALL verify that angle=11, speed=1, reverse=1 (a=33) gives dx=0 and dy=-255.
REQ-041 SHALL verify that angle=50 gives err=1, dx=dy=0, and out_valid on cycle 4.
REQ-042 SHALL verify that holding out_ready low 5 cycles keeps outputs stable and req_ready=0, and that a second request is taken only after the handshake.
REQ-043 SHALL verify that Reset_n pulsed low in COS gives out_valid=0, all outputs 0, and req_ready=1 in the cycle after release.
